// File: rtl/fetch_mem_wr_unit.sv
// Fetch / memory / write-back stage: program counter plus a unified code+data synchronous RAM.
// Latency: 1 cycle from the RAM access (fetch or load) to o_16_data_mem2cpu; write-back regs 1 cycle.
// Backpressure: none. A data access stalls the PC for that cycle; a taken branch overrides the PC.
//
// Ports:
//   clk, rst (async active-low)
//   o_16_data_mem2cpu : RAM read-data register (instruction or load data)
//   or_R_pcplus       : PC+2 of the instruction on o_16_data_mem2cpu
//   or_*              : write-back controls/result registered from execute
//   i_*               : execute-stage result, store data, branch and memory controls
// Optional build macro: MEM_BYTE_SWAP_EN swaps bytes on RAM read data and on store data.
module fetch_mem_wr_unit #(
   parameter int MEM_DEPTH  = 4096,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int REG_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [15:0]          o_16_data_mem2cpu,
   output logic [REG_WIDTH-1:0] or_R_pcplus,
   output logic [REG_WIDTH-1:0] or_R_alu_out,
   output logic                 or_1_mem2reg_sel,
   output logic [3:0]           or_4_reg_wr_addr,
   output logic                 or_1_reg_wr_en,
   input  logic                 i_1_alu_zero,
   input  logic [REG_WIDTH-1:0] i_R_alu_out,
   input  logic [REG_WIDTH-1:0] i_R_wr_data,
   input  logic [3:0]           i_4_reg_wr_addr,
   input  logic [REG_WIDTH-1:0] i_R_pc_branch,
   input  logic                 i_1_mem_addr_sel,
   input  logic                 i_1_reg_wr_en,
   input  logic                 i_1_mem2reg_sel,
   input  logic                 i_1_mem_wr_en,
   input  logic                 i_1_branch
);

   // Unified code/data store; intentionally not reset so preloaded images survive reset.
   logic [15:0] ram [MEM_DEPTH];

   logic [REG_WIDTH-1:0]  pc;
   logic [REG_WIDTH-1:0]  pc_next;
   logic [REG_WIDTH-1:0]  pc_plus2;
   logic [ADDR_WIDTH-1:0] fetch_word;
   logic [ADDR_WIDTH-1:0] data_word;
   logic                  do_store;
   logic                  ram_we;
   logic                  branch_taken;

   function automatic logic [15:0] swap_bytes(input logic [15:0] d);
`ifdef MEM_BYTE_SWAP_EN
      return {d[7:0], d[15:8]};
`else
      return d;
`endif
   endfunction

   // Byte addresses: drop bit 0, keep ADDR_WIDTH bits so accesses wrap modulo MEM_DEPTH.
   assign fetch_word   = pc[ADDR_WIDTH:1];
   assign data_word    = i_R_alu_out[ADDR_WIDTH:1];
   assign pc_plus2     = pc + REG_WIDTH'(2);
   assign branch_taken = i_1_branch & i_1_alu_zero;

   // A store request is only honoured on a data-access cycle.
   assign do_store = i_1_mem_addr_sel & i_1_mem_wr_en;
   // Gating with rst makes an edge that arrives while reset is held (e.g. reset asserted
   // mid-store) perform no write.
   assign ram_we   = do_store & rst;

   // Taken branch wins over both increment and the data-access stall.
   always_comb begin
      pc_next = pc_plus2;
      if (branch_taken)
         pc_next = {i_R_pc_branch[REG_WIDTH-1:1], 1'b0};
      else if (i_1_mem_addr_sel)
         pc_next = pc;
   end

   always_ff @(posedge clk) begin
      if (ram_we)
         ram[data_word] <= swap_bytes(i_R_wr_data[15:0]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc                <= '0;
         o_16_data_mem2cpu <= '0;
         or_R_pcplus       <= '0;
         or_R_alu_out      <= '0;
         or_1_mem2reg_sel  <= 1'b0;
         or_4_reg_wr_addr  <= '0;
         or_1_reg_wr_en    <= 1'b0;
      end else begin
         pc               <= pc_next;
         or_R_alu_out     <= i_R_alu_out;
         or_1_mem2reg_sel <= i_1_mem2reg_sel;
         or_4_reg_wr_addr <= i_4_reg_wr_addr;
         or_1_reg_wr_en   <= i_1_reg_wr_en;
         if (!i_1_mem_addr_sel) begin
            // Fetch: instruction and its PC+2 move together.
            o_16_data_mem2cpu <= swap_bytes(ram[fetch_word]);
            or_R_pcplus       <= pc_plus2;
         end else if (!i_1_mem_wr_en) begin
            // Load: pcplus keeps describing the last fetched instruction.
            o_16_data_mem2cpu <= swap_bytes(ram[data_word]);
         end
         // Store: read-data register holds its previous value.
      end
   end

   // Address bits outside the word index and store-data bits above 16 are don't-care.
   logic unused_bits;
   assign unused_bits = ^{i_R_alu_out, i_R_pc_branch[0], pc, i_R_wr_data};

endmodule

// File: tb/tb_fetch_mem_wr_unit.sv
module tb_fetch_mem_wr_unit;

   logic        clk;
   logic        rst;
   logic [15:0] o_16_data_mem2cpu;
   logic [15:0] or_R_pcplus;
   logic [15:0] or_R_alu_out;
   logic        or_1_mem2reg_sel;
   logic [3:0]  or_4_reg_wr_addr;
   logic        or_1_reg_wr_en;
   logic        i_1_alu_zero;
   logic [15:0] i_R_alu_out;
   logic [15:0] i_R_wr_data;
   logic [3:0]  i_4_reg_wr_addr;
   logic [15:0] i_R_pc_branch;
   logic        i_1_mem_addr_sel;
   logic        i_1_reg_wr_en;
   logic        i_1_mem2reg_sel;
   logic        i_1_mem_wr_en;
   logic        i_1_branch;

   int checks = 0;
   int errors = 0;

   fetch_mem_wr_unit dut (
      .clk               (clk),
      .rst               (rst),
      .o_16_data_mem2cpu (o_16_data_mem2cpu),
      .or_R_pcplus       (or_R_pcplus),
      .or_R_alu_out      (or_R_alu_out),
      .or_1_mem2reg_sel  (or_1_mem2reg_sel),
      .or_4_reg_wr_addr  (or_4_reg_wr_addr),
      .or_1_reg_wr_en    (or_1_reg_wr_en),
      .i_1_alu_zero      (i_1_alu_zero),
      .i_R_alu_out       (i_R_alu_out),
      .i_R_wr_data       (i_R_wr_data),
      .i_4_reg_wr_addr   (i_4_reg_wr_addr),
      .i_R_pc_branch     (i_R_pc_branch),
      .i_1_mem_addr_sel  (i_1_mem_addr_sel),
      .i_1_reg_wr_en     (i_1_reg_wr_en),
      .i_1_mem2reg_sel   (i_1_mem2reg_sel),
      .i_1_mem_wr_en     (i_1_mem_wr_en),
      .i_1_branch        (i_1_branch)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] sw(input logic [15:0] d);
`ifdef MEM_BYTE_SWAP_EN
      return {d[7:0], d[15:8]};
`else
      return d;
`endif
   endfunction

   // Advance one rising edge, then sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_1_alu_zero     = 1'b0;
      i_R_alu_out      = '0;
      i_R_wr_data      = '0;
      i_4_reg_wr_addr  = '0;
      i_R_pc_branch    = '0;
      i_1_mem_addr_sel = 1'b0;
      i_1_reg_wr_en    = 1'b0;
      i_1_mem2reg_sel  = 1'b0;
      i_1_mem_wr_en    = 1'b0;
      i_1_branch       = 1'b0;
   endtask

   task automatic test_reset();
      i_R_alu_out     = 16'h0005;
      i_1_reg_wr_en   = 1'b1;
      i_4_reg_wr_addr = 4'h7;
      tick();
      checks++;
      if (o_16_data_mem2cpu !== 16'h0 || or_R_pcplus !== 16'h0) begin
         errors++;
         $display("FAIL reset_data_pc data=%h pcplus=%h required 0/0", o_16_data_mem2cpu, or_R_pcplus);
      end
      checks++;
      if (or_R_alu_out !== 16'h0 || or_1_mem2reg_sel !== 1'b0 || or_4_reg_wr_addr !== 4'h0 || or_1_reg_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_wb alu=%h m2r=%b addr=%h en=%b required 0", or_R_alu_out, or_1_mem2reg_sel, or_4_reg_wr_addr, or_1_reg_wr_en);
      end
      clear_inputs();
      rst = 1'b1;
   endtask

   task automatic test_fetch();
      logic [15:0] words [4];
      words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (o_16_data_mem2cpu !== sw(words[i]) || or_R_pcplus !== 16'(2 * (i + 1))) begin
            errors++;
            $display("FAIL fetch%0d data=%h pcplus=%h required %h/%h", i, o_16_data_mem2cpu, or_R_pcplus, sw(words[i]), 16'(2 * (i + 1)));
         end
      end
   endtask

   task automatic test_store_load();
      i_1_mem_addr_sel = 1'b1;
      i_1_mem_wr_en    = 1'b1;
      i_R_alu_out      = 16'h0010;
      i_R_wr_data      = 16'hBEEF;
      tick();
      checks++;
      if (o_16_data_mem2cpu !== sw(16'h4444) || or_R_pcplus !== 16'h0008) begin
         errors++;
         $display("FAIL store_hold data=%h pcplus=%h required %h/0008", o_16_data_mem2cpu, or_R_pcplus, sw(16'h4444));
      end
      checks++;
      if (dut.ram[8] !== sw(16'hBEEF)) begin
         errors++;
         $display("FAIL store_ram ram[8]=%h required %h", dut.ram[8], sw(16'hBEEF));
      end
      i_1_mem_wr_en = 1'b0;
      i_R_alu_out   = 16'h0011;
      tick();
      checks++;
      if (o_16_data_mem2cpu !== 16'hBEEF || or_R_pcplus !== 16'h0008) begin
         errors++;
         $display("FAIL load data=%h pcplus=%h required BEEF/0008", o_16_data_mem2cpu, or_R_pcplus);
      end
      i_1_mem_addr_sel = 1'b0;
      tick();
      checks++;
      if (o_16_data_mem2cpu !== sw(16'h5555) || or_R_pcplus !== 16'h000A) begin
         errors++;
         $display("FAIL fetch_resume data=%h pcplus=%h required %h/000a", o_16_data_mem2cpu, or_R_pcplus, sw(16'h5555));
      end
   endtask

   task automatic test_branch();
      i_1_branch    = 1'b1;
      i_1_alu_zero  = 1'b1;
      i_R_pc_branch = 16'h0020;
      tick();
      checks++;
      if (o_16_data_mem2cpu !== sw(16'h6666) || or_R_pcplus !== 16'h000C) begin
         errors++;
         $display("FAIL branch_issue data=%h pcplus=%h required %h/000c", o_16_data_mem2cpu, or_R_pcplus, sw(16'h6666));
      end
      clear_inputs();
      tick();
      checks++;
      if (o_16_data_mem2cpu !== sw(16'h1616) || or_R_pcplus !== 16'h0022) begin
         errors++;
         $display("FAIL branch_taken data=%h pcplus=%h required %h/0022", o_16_data_mem2cpu, or_R_pcplus, sw(16'h1616));
      end
      i_1_branch    = 1'b1;
      i_1_alu_zero  = 1'b0;
      i_R_pc_branch = 16'h0040;
      tick();
      clear_inputs();
      tick();
      checks++;
      if (o_16_data_mem2cpu !== sw(16'h1818) || or_R_pcplus !== 16'h0026) begin
         errors++;
         $display("FAIL branch_not_taken data=%h pcplus=%h required %h/0026", o_16_data_mem2cpu, or_R_pcplus, sw(16'h1818));
      end
      // Taken branch during a load, odd target: PC must move to 0x20 anyway.
      i_1_mem_addr_sel = 1'b1;
      i_R_alu_out      = 16'h0002;
      i_1_branch       = 1'b1;
      i_1_alu_zero     = 1'b1;
      i_R_pc_branch    = 16'h0021;
      tick();
      checks++;
      if (o_16_data_mem2cpu !== sw(16'h2222) || or_R_pcplus !== 16'h0026) begin
         errors++;
         $display("FAIL branch_in_load data=%h pcplus=%h required %h/0026", o_16_data_mem2cpu, or_R_pcplus, sw(16'h2222));
      end
      clear_inputs();
      tick();
      checks++;
      if (o_16_data_mem2cpu !== sw(16'h1616) || or_R_pcplus !== 16'h0022) begin
         errors++;
         $display("FAIL branch_after_load data=%h pcplus=%h required %h/0022", o_16_data_mem2cpu, or_R_pcplus, sw(16'h1616));
      end
   endtask

   task automatic test_wb_pipeline();
      i_R_alu_out     = 16'h0005;
      i_4_reg_wr_addr = 4'h3;
      i_1_reg_wr_en   = 1'b1;
      i_1_mem2reg_sel = 1'b0;
      tick();
      checks++;
      if (or_R_alu_out !== 16'h0005 || or_4_reg_wr_addr !== 4'h3 || or_1_reg_wr_en !== 1'b1 || or_1_mem2reg_sel !== 1'b0) begin
         errors++;
         $display("FAIL wb_alu alu=%h addr=%h en=%b m2r=%b required 0005/3/1/0", or_R_alu_out, or_4_reg_wr_addr, or_1_reg_wr_en, or_1_mem2reg_sel);
      end
      // Load with write-back controls: data and controls must line up.
      i_1_mem_addr_sel = 1'b1;
      i_R_alu_out      = 16'hA5A5;
      i_4_reg_wr_addr  = 4'hC;
      i_1_reg_wr_en    = 1'b0;
      i_1_mem2reg_sel  = 1'b1;
      tick();
      checks++;
      if (or_R_alu_out !== 16'hA5A5 || or_4_reg_wr_addr !== 4'hC || or_1_reg_wr_en !== 1'b0 || or_1_mem2reg_sel !== 1'b1 || o_16_data_mem2cpu !== sw(16'h2D2D)) begin
         errors++;
         $display("FAIL wb_load alu=%h addr=%h en=%b m2r=%b data=%h required a5a5/c/0/1/%h", or_R_alu_out, or_4_reg_wr_addr, or_1_reg_wr_en, or_1_mem2reg_sel, o_16_data_mem2cpu, sw(16'h2D2D));
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (or_R_alu_out !== 16'h0 || or_4_reg_wr_addr !== 4'h0 || or_1_mem2reg_sel !== 1'b0 || o_16_data_mem2cpu !== 16'h0) begin
         errors++;
         $display("FAIL wb_reset alu=%h addr=%h m2r=%b data=%h required 0", or_R_alu_out, or_4_reg_wr_addr, or_1_mem2reg_sel, o_16_data_mem2cpu);
      end
      clear_inputs();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_wrap();
      i_1_mem_addr_sel = 1'b1;
      i_R_alu_out      = 16'h2000;
      tick();
      checks++;
      if (o_16_data_mem2cpu !== sw(16'h1111) || or_R_pcplus !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_load data=%h pcplus=%h required %h/0000", o_16_data_mem2cpu, or_R_pcplus, sw(16'h1111));
      end
      clear_inputs();
      i_1_branch    = 1'b1;
      i_1_alu_zero  = 1'b1;
      i_R_pc_branch = 16'h1FFE;
      tick();
      clear_inputs();
      tick();
      checks++;
      if (o_16_data_mem2cpu !== sw(16'hF0F0) || or_R_pcplus !== 16'h2000) begin
         errors++;
         $display("FAIL wrap_top data=%h pcplus=%h required %h/2000", o_16_data_mem2cpu, or_R_pcplus, sw(16'hF0F0));
      end
      tick();
      checks++;
      if (o_16_data_mem2cpu !== sw(16'h1111) || or_R_pcplus !== 16'h2002) begin
         errors++;
         $display("FAIL wrap_zero data=%h pcplus=%h required %h/2002", o_16_data_mem2cpu, or_R_pcplus, sw(16'h1111));
      end
   endtask

   task automatic test_ignored_write();
      i_1_mem_wr_en = 1'b1;
      i_R_alu_out   = 16'h0030;
      i_R_wr_data   = 16'hDEAD;
      tick();
      checks++;
      if (dut.ram[24] !== 16'h2424) begin
         errors++;
         $display("FAIL ignored_write ram[24]=%h required 2424", dut.ram[24]);
      end
      checks++;
      if (o_16_data_mem2cpu !== sw(16'h2222) || or_R_pcplus !== 16'h2004) begin
         errors++;
         $display("FAIL ignored_write_fetch data=%h pcplus=%h required %h/2004", o_16_data_mem2cpu, or_R_pcplus, sw(16'h2222));
      end
   endtask

   task automatic test_async_reset();
      i_1_mem_addr_sel = 1'b1;
      i_1_mem_wr_en    = 1'b1;
      i_R_alu_out      = 16'h0032;
      i_R_wr_data      = 16'hDEAD;
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if (o_16_data_mem2cpu !== 16'h0 || or_R_pcplus !== 16'h0 || or_R_alu_out !== 16'h0) begin
         errors++;
         $display("FAIL async_reset data=%h pcplus=%h alu=%h required 0", o_16_data_mem2cpu, or_R_pcplus, or_R_alu_out);
      end
      tick();
      checks++;
      if (dut.ram[25] !== 16'h2525) begin
         errors++;
         $display("FAIL reset_store_abort ram[25]=%h required 2525", dut.ram[25]);
      end
      clear_inputs();
      rst = 1'b1;
      tick();
      checks++;
      if (o_16_data_mem2cpu !== sw(16'h1111) || or_R_pcplus !== 16'h0002) begin
         errors++;
         $display("FAIL first_fetch_after_reset data=%h pcplus=%h required %h/0002", o_16_data_mem2cpu, or_R_pcplus, sw(16'h1111));
      end
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      dut.ram[0]     = 16'h1111;
      dut.ram[1]     = 16'h2222;
      dut.ram[2]     = 16'h3333;
      dut.ram[3]     = 16'h4444;
      dut.ram[4]     = 16'h5555;
      dut.ram[5]     = 16'h6666;
      dut.ram[8]     = 16'h0000;
      dut.ram[16]    = 16'h1616;
      dut.ram[17]    = 16'h1717;
      dut.ram[18]    = 16'h1818;
      dut.ram[24]    = 16'h2424;
      dut.ram[25]    = 16'h2525;
      dut.ram[12'h2D2] = 16'h2D2D;
      dut.ram[4095]  = 16'hF0F0;
      #3;
      test_reset();
      test_fetch();
      test_store_load();
      test_branch();
      test_wb_pipeline();
      test_wrap();
      test_ignored_write();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
